// File: rtl/adder_sched.sv
// Round-robin scheduler that time-shares one combinational adder between two
// requesters, holding the operand for SETTLE cycles and answering via req/ack.
module adder_sched #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] opnd0,
  input  logic [3:0] opnd1,
  output logic [1:0] ack,
  output logic [4:0] rsp0,
  output logic [4:0] rsp1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [3:0] add_opnd,
  input  logic [4:0] add_sum
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACK} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       last_q;
  logic       win_q;
  logic [1:0] ack_q;
  logic [1:0] gnt_q;
  logic       busy_q;
  logic [3:0] add_opnd_q;
  logic [4:0] rsp0_q;
  logic [4:0] rsp1_q;
  logic       sel_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel_d = req[1];
    if (req == 2'b11) begin
      sel_d = ~last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      ack_q      <= 2'b00;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      add_opnd_q <= 4'd0;
      rsp0_q     <= 5'd0;
      rsp1_q     <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            win_q      <= sel_d;
            add_opnd_q <= sel_d ? opnd1 : opnd0;
            gnt_q      <= sel_d ? 2'b10 : 2'b01;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b1;
            state_q    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            if (win_q) begin
              rsp1_q <= add_sum;
            end else begin
              rsp0_q <= add_sum;
            end
            ack_q   <= win_q ? 2'b10 : 2'b01;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          // Release once the owner's request is seen low, even if it fell early.
          if (!req[win_q]) begin
            ack_q      <= 2'b00;
            gnt_q      <= 2'b00;
            add_opnd_q <= 4'd0;
            last_q     <= win_q;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign add_opnd = add_opnd_q;
  assign rsp0     = rsp0_q;
  assign rsp1     = rsp1_q;

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: instance 0 uses SETTLE=1, instance 1 uses SETTLE=4,
// each with a behavioural adder of sum = operand + 11.
module tb_adder_sched;

  typedef struct packed {
    logic       w;
    logic [4:0] r;
  } sb_t;

  typedef struct packed {
    logic [1:0] req;
    logic [3:0] o0;
    logic [3:0] o1;
    logic [1:0] gnt;
    logic [4:0] rsp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_v  [2];
  logic [3:0] o0_v   [2];
  logic [3:0] o1_v   [2];
  logic [1:0] ack_v  [2];
  logic [4:0] rsp0_v [2];
  logic [4:0] rsp1_v [2];
  logic [1:0] gnt_v  [2];
  logic       busy_v [2];
  logic [3:0] aop_v  [2];
  logic [4:0] sum_v  [2];

  logic [4:0] exp0 [2];
  logic [4:0] exp1 [2];
  logic [1:0] ack_prev [2];
  sb_t        sb0 [$];
  sb_t        sb1 [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    adder_sched #(.SETTLE(gi == 0 ? 1 : 4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_v[gi]),
      .opnd0    (o0_v[gi]),
      .opnd1    (o1_v[gi]),
      .ack      (ack_v[gi]),
      .rsp0     (rsp0_v[gi]),
      .rsp1     (rsp1_v[gi]),
      .gnt      (gnt_v[gi]),
      .busy     (busy_v[gi]),
      .add_opnd (aop_v[gi]),
      .add_sum  (sum_v[gi])
    );
    assign sum_v[gi] = {1'b0, aop_v[gi]} + 5'd11;
  end

  function automatic logic [4:0] model(input logic [3:0] o);
    return {1'b0, o} + 5'd11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic st(input int d, input string nm, input logic [1:0] g, input logic [1:0] a,
                    input logic b, input logic [3:0] op);
    chk({nm, "_gnt"},  32'(gnt_v[d]),  32'(g));
    chk({nm, "_ack"},  32'(ack_v[d]),  32'(a));
    chk({nm, "_busy"}, 32'(busy_v[d]), 32'(b));
    chk({nm, "_opnd"}, 32'(aop_v[d]),  32'(op));
  endtask

  task automatic rsp_chk(input int d, input string nm);
    chk({nm, "_rsp0"}, 32'(rsp0_v[d]), 32'(exp0[d]));
    chk({nm, "_rsp1"}, 32'(rsp1_v[d]), 32'(exp1[d]));
  endtask

  task automatic push(input int d, input logic w, input logic [4:0] r);
    sb_t e;
    e.w = w;
    e.r = r;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Scoreboard: every rising ack must match the oldest expected transaction.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && ack_v[d] != 2'b00 && ack_prev[d] == 2'b00) begin
        sb_t e;
        logic got;
        got = 1'b0;
        e = '0;
        if (d == 0 && sb0.size() > 0) begin
          e = sb0.pop_front();
          got = 1'b1;
        end else if (d == 1 && sb1.size() > 0) begin
          e = sb1.pop_front();
          got = 1'b1;
        end
        if (!got) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected dut=%0d actual ack=%0b required no ack", d, ack_v[d]);
        end else begin
          chk("sb_ack", 32'(ack_v[d]), e.w ? 32'd2 : 32'd1);
          chk("sb_rsp", e.w ? 32'(rsp1_v[d]) : 32'(rsp0_v[d]), 32'(e.r));
          $display("txn dut=%0d requester=%0d rsp=%0h expected=%0h", d, e.w,
                   e.w ? rsp1_v[d] : rsp0_v[d], e.r);
        end
      end
      ack_prev[d] <= ack_v[d];
    end
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = '{req: 2'b01, o0: 4'hA, o1: 4'h0, gnt: 2'b01, rsp: 5'h15};
    vecs[1] = '{req: 2'b10, o0: 4'h1, o1: 4'hF, gnt: 2'b10, rsp: 5'h1A};
    vecs[2] = '{req: 2'b11, o0: 4'h3, o1: 4'h5, gnt: 2'b01, rsp: 5'h0E};
    vecs[3] = '{req: 2'b11, o0: 4'h7, o1: 4'h9, gnt: 2'b10, rsp: 5'h14};
    vecs[4] = '{req: 2'b11, o0: 4'h0, o1: 4'hF, gnt: 2'b01, rsp: 5'h0B};
    vecs[5] = '{req: 2'b01, o0: 4'hF, o1: 4'h0, gnt: 2'b01, rsp: 5'h1A};
    vecs[6] = '{req: 2'b11, o0: 4'h2, o1: 4'h4, gnt: 2'b10, rsp: 5'h0F};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 2'b00;
      o0_v[d]  = 4'h0;
      o1_v[d]  = 4'h0;
      exp0[d]  = 5'h00;
      exp1[d]  = 5'h00;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      st(d, "reset", 2'b00, 2'b00, 1'b0, 4'h0);
      rsp_chk(d, "reset");
    end
    rst_n = 1'b1;

    // Tie from reset, then round-robin hand-over with one IDLE cycle.
    @(negedge clk);
    req_v[0] = 2'b11; o0_v[0] = 4'h3; o1_v[0] = 4'h5;
    push(0, 1'b0, model(4'h3));
    push(0, 1'b1, model(4'h5));
    @(negedge clk); st(0, "rr_g0", 2'b01, 2'b00, 1'b1, 4'h3);
    @(negedge clk); exp0[0] = 5'h0E; st(0, "rr_a0", 2'b01, 2'b01, 1'b1, 4'h3); rsp_chk(0, "rr_a0");
    req_v[0] = 2'b10;
    @(negedge clk); st(0, "rr_idle", 2'b00, 2'b00, 1'b0, 4'h0);
    @(negedge clk); st(0, "rr_g1", 2'b10, 2'b00, 1'b1, 4'h5);
    @(negedge clk); exp1[0] = 5'h10; st(0, "rr_a1", 2'b10, 2'b10, 1'b1, 4'h5); rsp_chk(0, "rr_a1");
    req_v[0] = 2'b00;
    @(negedge clk); st(0, "rr_rel1", 2'b00, 2'b00, 1'b0, 4'h0);
    req_v[0] = 2'b11; o0_v[0] = 4'h6; o1_v[0] = 4'h8;
    push(0, 1'b0, model(4'h6));
    @(negedge clk); st(0, "rr_g2", 2'b01, 2'b00, 1'b1, 4'h6);
    @(negedge clk); exp0[0] = 5'h11; st(0, "rr_a2", 2'b01, 2'b01, 1'b1, 4'h6); rsp_chk(0, "rr_a2");
    req_v[0] = 2'b00;
    @(negedge clk); st(0, "rr_rel2", 2'b00, 2'b00, 1'b0, 4'h0);

    // Table of complete single-cycle-settle transactions.
    for (int i = 0; i < 7; i++) begin
      logic       w;
      logic [3:0] op;
      @(negedge clk);
      req_v[0] = vecs[i].req; o0_v[0] = vecs[i].o0; o1_v[0] = vecs[i].o1;
      w  = vecs[i].gnt[1];
      op = w ? vecs[i].o1 : vecs[i].o0;
      push(0, w, vecs[i].rsp);
      @(negedge clk); st(0, "vec_grant", vecs[i].gnt, 2'b00, 1'b1, op);
      @(negedge clk);
      if (w) exp1[0] = vecs[i].rsp;
      else   exp0[0] = vecs[i].rsp;
      st(0, "vec_ack", vecs[i].gnt, vecs[i].gnt, 1'b1, op);
      rsp_chk(0, "vec");
      req_v[0] = 2'b00;
      @(negedge clk); st(0, "vec_rel", 2'b00, 2'b00, 1'b0, 4'h0);
    end

    // Operand stability with SETTLE=4.
    @(negedge clk);
    req_v[1] = 2'b01; o0_v[1] = 4'h5;
    push(1, 1'b0, 5'h10);
    @(negedge clk); st(1, "stab_g", 2'b01, 2'b00, 1'b1, 4'h5);
    for (int j = 0; j < 3; j++) begin
      o0_v[1] = 4'($urandom_range(0, 15));
      @(negedge clk); st(1, "stab_hold", 2'b01, 2'b00, 1'b1, 4'h5);
    end
    o0_v[1] = 4'hE;
    @(negedge clk); exp0[1] = 5'h10; st(1, "stab_ack", 2'b01, 2'b01, 1'b1, 4'h5); rsp_chk(1, "stab");
    req_v[1] = 2'b00;
    @(negedge clk); st(1, "stab_rel", 2'b00, 2'b00, 1'b0, 4'h0);

    // Early release by requester 1 during settle.
    @(negedge clk);
    req_v[1] = 2'b10; o1_v[1] = 4'h2;
    push(1, 1'b1, 5'h0D);
    @(negedge clk); st(1, "early_g", 2'b10, 2'b00, 1'b1, 4'h2);
    req_v[1] = 2'b00;
    repeat (3) begin
      @(negedge clk); st(1, "early_wait", 2'b10, 2'b00, 1'b1, 4'h2);
    end
    @(negedge clk); exp1[1] = 5'h0D; st(1, "early_ack", 2'b10, 2'b10, 1'b1, 4'h2); rsp_chk(1, "early");
    @(negedge clk); st(1, "early_rel", 2'b00, 2'b00, 1'b0, 4'h0);

    // Held ack with requester 1 pending.
    @(negedge clk);
    req_v[0] = 2'b01; o0_v[0] = 4'hC;
    push(0, 1'b0, 5'h17);
    @(negedge clk); st(0, "hold_g0", 2'b01, 2'b00, 1'b1, 4'hC);
    req_v[0] = 2'b11; o1_v[0] = 4'h1;
    push(0, 1'b1, 5'h0C);
    @(negedge clk); exp0[0] = 5'h17; st(0, "hold_a0", 2'b01, 2'b01, 1'b1, 4'hC); rsp_chk(0, "hold_a0");
    repeat (10) begin
      @(negedge clk); st(0, "hold", 2'b01, 2'b01, 1'b1, 4'hC);
    end
    req_v[0] = 2'b10;
    @(negedge clk); st(0, "hold_rel", 2'b00, 2'b00, 1'b0, 4'h0);
    @(negedge clk); st(0, "hold_g1", 2'b10, 2'b00, 1'b1, 4'h1);
    @(negedge clk); exp1[0] = 5'h0C; st(0, "hold_a1", 2'b10, 2'b10, 1'b1, 4'h1); rsp_chk(0, "hold_a1");
    req_v[0] = 2'b00;
    @(negedge clk); st(0, "hold_rel1", 2'b00, 2'b00, 1'b0, 4'h0);

    // Asynchronous reset in the middle of a SETTLE=4 transaction.
    @(negedge clk);
    req_v[1] = 2'b01; o0_v[1] = 4'h9;
    @(negedge clk); st(1, "rst_g", 2'b01, 2'b00, 1'b1, 4'h9);
    @(negedge clk); st(1, "rst_mid", 2'b01, 2'b00, 1'b1, 4'h9);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp0[d] = 5'h00;
      exp1[d] = 5'h00;
      st(d, "async_rst", 2'b00, 2'b00, 1'b0, 4'h0);
      rsp_chk(d, "async_rst");
    end
    req_v[1] = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    st(1, "post_rst", 2'b00, 2'b00, 1'b0, 4'h0);
    rsp_chk(1, "post_rst");
    chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
